// File: rtl/int_to_ieee754_seq_if.sv
// Stream handshake bundle for the integer-to-float converter: operand in, IEEE-754 single out.
// The master side drives operands and out_ready; the slave side is the converter.
interface int_to_ieee754_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] int_in;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      ieee754;
    logic             inexact;

    modport master (
        output in_valid, int_in, out_ready,
        input  in_ready, out_valid, ieee754, inexact
    );

    modport slave (
        input  in_valid, int_in, out_ready,
        output in_ready, out_valid, ieee754, inexact
    );
endinterface

// File: rtl/int_to_ieee754_seq.sv
// Signed integer -> IEEE-754 single, one normalising shift per cycle; ROUND_NEAREST_EN selects RNE over truncation.
// Latency k+2 edges after accept (k = leading zeros), zero done on the accept edge; result held until out_ready, one op in flight.
module int_to_ieee754_seq #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    int_to_ieee754_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    localparam logic [7:0] EXP_INIT = 8'(126 + WIDTH);
    localparam int         EXT_W    = WIDTH + 22;

    state_t           state;
    state_t           state_nxt;
    logic             sign;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] mag_in;
    logic [7:0]       exp_q;
    logic [31:0]      ieee_q;
    logic             inexact_q;

    logic [EXT_W-1:0] ext;
    logic [22:0]      frac_t;
    logic [WIDTH-2:0] disc;
    logic             round_inc;
    logic [23:0]      frac_sum;
    logic [22:0]      frac_r;
    logic [7:0]       exp_r;

    // Negating the most negative value wraps back to 2^(WIDTH-1), which is the correct magnitude.
    assign mag_in = bus.int_in[WIDTH-1] ? (~bus.int_in + WIDTH'(1)) : bus.int_in;

    always_comb begin
        ext    = {mag[WIDTH-2:0], 23'd0};
        frac_t = ext[EXT_W-1 -: 23];
        disc   = ext[WIDTH-2:0];
`ifdef ROUND_NEAREST_EN
        round_inc = disc[WIDTH-2] & ((|disc[WIDTH-3:0]) | frac_t[0]);
`else
        round_inc = 1'b0;
`endif
        // A carry out of the fraction leaves its low 23 bits at zero and bumps the exponent.
        frac_sum = {1'b0, frac_t} + {23'd0, round_inc};
        frac_r   = frac_sum[22:0];
        exp_r    = exp_q + {7'd0, frac_sum[23]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = (mag_in == '0) ? DONE : NORM;
            NORM:    if (mag[WIDTH-1]) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign      <= 1'b0;
            mag       <= '0;
            exp_q     <= 8'd0;
            ieee_q    <= 32'd0;
            inexact_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign  <= bus.int_in[WIDTH-1];
                        mag   <= mag_in;
                        exp_q <= EXP_INIT;
                        if (mag_in == '0) begin
                            ieee_q    <= 32'd0;
                            inexact_q <= 1'b0;
                        end
                    end
                end
                NORM: begin
                    if (!mag[WIDTH-1]) begin
                        mag   <= {mag[WIDTH-2:0], 1'b0};
                        exp_q <= exp_q - 8'd1;
                    end
                end
                ROUND: begin
                    ieee_q    <= {sign, exp_r, frac_r};
                    inexact_q <= |disc;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.ieee754   = ieee_q;
    assign bus.inexact   = inexact_q;
endmodule

// File: tb/tb_int_to_ieee754_seq.sv
// Bench for int_to_ieee754_seq: directed corner cases plus random operands against an arithmetic float model.
module tb_int_to_ieee754_seq;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    int_to_ieee754_seq_if #(.WIDTH(32)) bus ();

    int_to_ieee754_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    // Reference: locate the leading one, keep 24 significant bits, inspect the remainder.
    function automatic void ref_conv(input logic [31:0] x, output logic [31:0] f,
                                     output logic inx, output int lat);
        longint m, sig, rem, half;
        int     p, e;
        logic   s;
        if (x == 32'd0) begin
            f = 32'd0; inx = 1'b0; lat = 0;  // zero finishes on the accept edge itself
            return;
        end
        s = x[31];
        m = s ? -longint'($signed(x)) : longint'(x);
        p = 0;
        for (int i = 0; i < 40; i++) if (m >= (longint'(1) << i)) p = i;
        e = 127 + p;
        if (p <= 23) begin
            sig = m << (23 - p); rem = 0; half = 1;
        end else begin
            sig  = m >> (p - 23);
            rem  = m - (sig << (p - 23));
            half = longint'(1) << (p - 24);
        end
        inx = (rem != 0);
`ifdef ROUND_NEAREST_EN
        if (rem > half || (rem == half && (sig % 2) == 1)) begin
            sig++;
            if (sig == (longint'(1) << 24)) begin
                sig = sig >> 1;
                e++;
            end
        end
`endif
        f   = {s, 8'(e), 23'(sig)};
        lat = (31 - p) + 2;
    endfunction

    task automatic run(input logic [31:0] x, input int hold, input string tag,
                       output logic [31:0] got_f, output logic got_inx);
        logic [31:0] f;
        logic        inx;
        int          lat, edges;
        ref_conv(x, f, inx, lat);
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.int_in   = x;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.int_in   = $urandom;
        edges = 0;
        while (!bus.out_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, ".latency"}, 32'(edges), 32'(lat));
        check({tag, ".ieee754"}, bus.ieee754, f);
        check({tag, ".inexact"}, 32'(bus.inexact), 32'(inx));
        got_f   = bus.ieee754;
        got_inx = bus.inexact;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            bus.int_in   = $urandom;
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, ".hold_ready"}, 32'(bus.in_ready), 32'd0);
            check({tag, ".hold_ieee"}, bus.ieee754, f);
            check({tag, ".hold_inexact"}, 32'(bus.inexact), 32'(inx));
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, ".drain_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".drain_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] gf, x;
        logic        gi;
        int          seen;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.int_in    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.ieee754", bus.ieee754, 32'd0);
        check("rst.inexact", 32'(bus.inexact), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run(32'd1, 0, "one", gf, gi);
        check("one.const", gf, 32'h3F800000);
        run(32'hFFFFFFFF, 1, "neg_one", gf, gi);
        check("neg_one.const", gf, 32'hBF800000);
        run(32'd0, 0, "zero", gf, gi);
        check("zero.const", gf, 32'h00000000);
        run(32'h80000000, 0, "int_min", gf, gi);
        check("int_min.const", gf, 32'hCF000000);
        check("int_min.inexact_const", 32'(gi), 32'd0);
        run(32'd16777219, 0, "tie_even", gf, gi);
`ifdef ROUND_NEAREST_EN
        check("tie_even.const", gf, 32'h4B800002);
`else
        check("tie_even.const", gf, 32'h4B800001);
`endif
        check("tie_even.inexact_const", 32'(gi), 32'd1);
        run(32'h7FFFFFFF, 0, "int_max", gf, gi);
`ifdef ROUND_NEAREST_EN
        check("int_max.const", gf, 32'h4F000000);
`else
        check("int_max.const", gf, 32'h4EFFFFFF);
`endif
        check("int_max.inexact_const", 32'(gi), 32'd1);

        run(32'd12345, 5, "stall", gf, gi);

        for (int n = 0; n < 150; n++) begin
            x = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) x = -x;
            run(x, $urandom_range(0, 3), "rand", gf, gi);
        end

        // Reset while normalising must abandon the conversion without producing a result.
        @(negedge clk);
        bus.int_in   = 32'd1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst.in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst.ieee754", bus.ieee754, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("midrst.no_output", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
